// File: rtl/line_fetch_ctrl.sv
// Per-scanline framebuffer fetch: on each accepted line trigger, reads one display line
// as fixed-length bursts into the write bank of a ping-pong line buffer.
module line_fetch_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PIX_PER_WORD = 2,
  parameter int BURST_LEN    = 16,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              init_read_line,
  input  logic              init_new_frame,
  input  logic              v_blank,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              underrun_clr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_wbank,
  output logic [8:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              disp_bank,
  output logic              busy,
  output logic              underrun,
  output logic [1:0]        o_dbg_state
);

  // WORDS_PER_LINE must be a whole number of bursts.
  localparam int WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD;
  localparam int BURSTS         = WORDS_PER_LINE / BURST_LEN;
  localparam int STRIDE         = WORDS_PER_LINE * DATA_W / 8;
  localparam int BURST_BYTES    = BURST_LEN * DATA_W / 8;
  localparam int LINE_W         = $clog2(V_ACTIVE + 1);
  localparam int BEAT_W         = $clog2(BURST_LEN);
  localparam int BURST_W        = $clog2(BURSTS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_wr_bank;
  logic [LINE_W-1:0]   r_line_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic [BEAT_W-1:0]   r_beat;
  logic [BURST_W-1:0]  r_burst;
  logic [8:0]          r_word;

  logic                w_trig;
  logic [LINE_W-1:0]   w_line_sel;
  logic [ADDR_W-1:0]   w_base_sel;
  logic [ADDR_W-1:0]   w_line_start;

  // A new-frame trigger is honoured even during vertical blanking (pre-frame line).
  assign w_trig       = init_read_line & (~v_blank | init_new_frame);
  assign w_line_sel   = init_new_frame ? '0 : r_line_cnt;
  assign w_base_sel   = init_new_frame ? fb_base : r_base;
  assign w_line_start = w_base_sel + ADDR_W'(w_line_sel) * ADDR_W'(STRIDE);
  assign o_dbg_state  = r_state;

  // Request handshake: mem_req is held with mem_addr stable until a cycle where
  // mem_req and mem_gnt are both high; that cycle transfers the burst request and
  // mem_req drops on the following cycle. Read beats are accepted on mem_rvalid only.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_bank  <= 1'b0;
      r_line_cnt <= '0;
      r_base     <= '0;
      r_beat     <= '0;
      r_burst    <= '0;
      r_word     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      lb_we      <= 1'b0;
      lb_wbank   <= 1'b0;
      lb_waddr   <= '0;
      lb_wdata   <= '0;
      disp_bank  <= 1'b1;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      lb_we <= 1'b0;

      if (w_trig && r_state != S_IDLE) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end

      // Line counting advances on every accepted trigger, fetched or not.
      if (w_trig) begin
        if (init_new_frame) begin
          r_base     <= fb_base;
          r_line_cnt <= LINE_W'(1);
        end else if (r_line_cnt != LINE_W'(V_ACTIVE)) begin
          r_line_cnt <= r_line_cnt + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          if (w_trig) begin
            disp_bank <= r_wr_bank;
            r_wr_bank <= ~r_wr_bank;
            mem_req   <= 1'b1;
            mem_addr  <= w_line_start;
            busy      <= 1'b1;
            r_burst   <= '0;
            r_beat    <= '0;
            r_word    <= '0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req  <= 1'b0;
            mem_addr <= mem_addr + ADDR_W'(BURST_BYTES);
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (mem_rvalid) begin
            lb_we    <= 1'b1;
            lb_wbank <= r_wr_bank;
            lb_waddr <= r_word;
            lb_wdata <= mem_rdata;
            r_word   <= r_word + 9'd1;
            r_beat   <= r_beat + 1'b1;
            if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
              r_burst <= r_burst + 1'b1;
              if (r_burst == BURST_W'(BURSTS - 1)) begin
                r_state <= S_IDLE;
              end else begin
                mem_req <= 1'b1;
                r_state <= S_REQ;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Bench for line_fetch_ctrl: transaction-level line/bank model, a burst memory
// responder, and directed scenarios with literal address/bank expectations.
module tb_line_fetch_ctrl;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int WPL    = 320;
  localparam int BL     = 16;
  localparam int NB     = 20;
  localparam int STRIDE = 1280;
  localparam int BB     = 64;
  localparam int VA     = 480;
  localparam int LIMIT  = 3000;

  logic          pixel_clk = 1'b0;
  logic          reset;
  logic          init_read_line;
  logic          init_new_frame;
  logic          v_blank;
  logic [AW-1:0] fb_base;
  logic          underrun_clr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          lb_we;
  logic          lb_wbank;
  logic [8:0]    lb_waddr;
  logic [DW-1:0] lb_wdata;
  logic          disp_bank;
  logic          busy;
  logic          underrun;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [41:0]   exp_wr_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] seen_addr_q[$];
  logic          m_disp     = 1'b1;
  logic          m_wr_bank  = 1'b0;
  int            m_line_cnt = 0;
  logic [AW-1:0] m_base     = '0;
  logic          m_underrun = 1'b0;
  int            n_writes   = 0;
  logic          last_wbank = 1'b0;
  logic [8:0]    last_waddr = '0;

  // responder controls and state
  int            gnt_delay  = 0;
  bit            gap_mode   = 1'b0;
  int            stray_req  = 0;
  int            rs_wait    = 0;
  int            rs_beat    = 0;
  int            rs_stray   = 0;
  bit            rs_burst   = 1'b0;
  bit            rs_gap     = 1'b0;
  logic [AW-1:0] rs_addr    = '0;

  line_fetch_ctrl dut (
    .pixel_clk      (pixel_clk),
    .reset          (reset),
    .init_read_line (init_read_line),
    .init_new_frame (init_new_frame),
    .v_blank        (v_blank),
    .fb_base        (fb_base),
    .underrun_clr   (underrun_clr),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .lb_we          (lb_we),
    .lb_wbank       (lb_wbank),
    .lb_waddr       (lb_waddr),
    .lb_wdata       (lb_wdata),
    .disp_bank      (disp_bank),
    .busy           (busy),
    .underrun       (underrun),
    .o_dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 pixel_clk = ~pixel_clk;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // memory responder: grant after gnt_delay waiting cycles, then BL beats whose data
  // is the byte address of that word
  initial begin : responder
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge pixel_clk);
      #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (reset) begin
        rs_burst = 1'b0;
        rs_wait  = 0;
      end else if (rs_stray < stray_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_0000 + 32'(rs_stray);
        rs_stray++;
      end else if (rs_burst) begin
        rs_gap = gap_mode ? !rs_gap : 1'b0;
        if (!rs_gap) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rs_addr + 32'(4 * rs_beat);
          rs_beat++;
          if (rs_beat == BL) rs_burst = 1'b0;
        end
      end else if (mem_req) begin
        if (rs_wait < gnt_delay) begin
          rs_wait++;
        end else begin
          mem_gnt  = 1'b1;
          rs_addr  = mem_addr;
          rs_burst = 1'b1;
          rs_beat  = 0;
          rs_wait  = 0;
        end
      end
    end
  end

  // scoreboard: check outputs against the model, then fold this cycle's inputs into it
  initial begin : compare_model
    logic [41:0] e;
    bit          trig;
    int          line;
    forever begin
      @(negedge pixel_clk);
      if (reset) begin
        exp_wr_q.delete();
        exp_addr_q.delete();
        m_disp     = 1'b1;
        m_wr_bank  = 1'b0;
        m_line_cnt = 0;
        m_base     = '0;
        m_underrun = 1'b0;
      end else begin
        check("disp_bank", disp_bank, m_disp);
        check("underrun", underrun, m_underrun);
        check("busy", busy, exp_wr_q.size() != 0);
        if (mem_req) begin
          if (exp_addr_q.size() == 0) begin
            check("req_unexpected", mem_req, 1'b0);
          end else begin
            check("mem_addr", mem_addr, exp_addr_q[0]);
            if (mem_gnt) begin
              seen_addr_q.push_back(mem_addr);
              void'(exp_addr_q.pop_front());
            end
          end
        end
        if (lb_we) begin
          if (exp_wr_q.size() == 0) begin
            check("we_unexpected", lb_we, 1'b0);
          end else begin
            e = exp_wr_q.pop_front();
            check("lb_write", {lb_wbank, lb_waddr, lb_wdata}, e);
            n_writes++;
            last_wbank = lb_wbank;
            last_waddr = lb_waddr;
          end
        end

        trig = init_read_line && (!v_blank || init_new_frame);
        if (trig && exp_wr_q.size() != 0) m_underrun = 1'b1;
        else if (underrun_clr) m_underrun = 1'b0;
        if (trig) begin
          if (init_new_frame) begin
            m_base     = fb_base;
            line       = 0;
            m_line_cnt = 1;
          end else begin
            line = m_line_cnt;
            if (m_line_cnt < VA) m_line_cnt++;
          end
          if (exp_wr_q.size() == 0) begin
            m_disp    = m_wr_bank;
            m_wr_bank = !m_wr_bank;
            for (int b = 0; b < NB; b++)
              exp_addr_q.push_back(m_base + 32'(line * STRIDE) + 32'(b * BB));
            for (int w = 0; w < WPL; w++) begin
              e = {m_wr_bank, 9'(w), m_base + 32'(line * STRIDE) + 32'(4 * w)};
              exp_wr_q.push_back(e);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pulse(input bit nf, input bit vb, input logic [AW-1:0] base);
    init_read_line = 1'b1;
    init_new_frame = nf;
    v_blank        = vb;
    fb_base        = base;
    tick();
    init_read_line = 1'b0;
    init_new_frame = 1'b0;
    v_blank        = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge pixel_clk);
    while (busy && n < LIMIT) begin
      @(negedge pixel_clk);
      n++;
    end
    check({name, "_finished"}, n < LIMIT, 1'b1);
    check({name, "_all_written"}, exp_wr_q.size(), 0);
    tick();
  endtask

  task automatic count_req(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge pixel_clk);
      if (mem_req) cnt++;
    end
    tick();
  endtask

  initial begin : main
    int cnt;
    int n;
    reset          = 1'b1;
    init_read_line = 1'b0;
    init_new_frame = 1'b0;
    v_blank        = 1'b0;
    fb_base        = '0;
    underrun_clr   = 1'b0;
    repeat (2) @(negedge pixel_clk);
    check("rst_disp_bank", disp_bank, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick();
    reset = 1'b0;

    // T1: idle after reset
    count_req(10, cnt);
    check("t1_no_req", cnt, 0);
    check("t1_mem_addr", mem_addr, 32'h0);
    check("t1_lb_we", lb_we, 1'b0);
    check("t1_lb_wbank", lb_wbank, 1'b0);
    check("t1_lb_waddr", lb_waddr, 9'd0);
    check("t1_lb_wdata", lb_wdata, 32'h0);
    check("t1_underrun", underrun, 1'b0);
    check("t1_disp_bank", disp_bank, 1'b1);

    // T2: line 0 of a new frame, issued during blanking
    seen_addr_q.delete();
    n_writes = 0;
    pulse(1'b1, 1'b1, 32'h1000_0000);
    check("t2_busy_rise", busy, 1'b1);
    wait_idle("t2");
    check("t2_bursts", seen_addr_q.size(), NB);
    if (seen_addr_q.size() == NB) begin
      check("t2_first_addr", seen_addr_q[0], 32'h1000_0000);
      check("t2_last_addr", seen_addr_q[NB-1], 32'h1000_04C0);
    end
    check("t2_writes", n_writes, WPL);
    check("t2_last_waddr", last_waddr, 9'd319);
    check("t2_wbank", last_wbank, 1'b1);
    check("t2_disp_bank", disp_bank, 1'b0);
    check("t2_busy_low", busy, 1'b0);

    // T3: next line, fb_base must not be re-latched
    seen_addr_q.delete();
    pulse(1'b0, 1'b0, 32'hDEAD_BEEF);
    wait_idle("t3");
    if (seen_addr_q.size() != 0) check("t3_first_addr", seen_addr_q[0], 32'h1000_0500);
    check("t3_disp_bank", disp_bank, 1'b1);
    check("t3_wbank", last_wbank, 1'b0);

    // blanked, non-frame pulse is ignored
    pulse(1'b0, 1'b1, 32'h0);
    count_req(6, cnt);
    check("ignored_pulse_no_req", cnt, 0);

    // T4: delayed grant holds request and address
    gnt_delay = 7;
    seen_addr_q.delete();
    pulse(1'b0, 1'b0, 32'hFFFF_0000);
    n   = 0;
    cnt = 0;
    @(negedge pixel_clk);
    while (mem_req && n < 50) begin
      if (mem_addr == 32'h1000_0A00) cnt++;
      n++;
      @(negedge pixel_clk);
    end
    check("t4_req_cycles", n, 8);
    check("t4_addr_stable", cnt, 8);
    check("t4_req_dropped", mem_req, 1'b0);
    wait_idle("t4");
    gnt_delay = 0;
    check("t4_disp_bank", disp_bank, 1'b0);

    // T5: underrun on a busy trigger, clear, and the skipped line
    gap_mode = 1'b1;
    pulse(1'b1, 1'b1, 32'h2000_0000);
    check("t5_disp_swap", disp_bank, 1'b1);
    repeat (30) tick();
    pulse(1'b0, 1'b0, 32'h0);
    check("t5_underrun_set", underrun, 1'b1);
    check("t5_disp_hold", disp_bank, 1'b1);
    repeat (3) tick();
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("t5_underrun_clr", underrun, 1'b0);
    wait_idle("t5a");
    seen_addr_q.delete();
    pulse(1'b0, 1'b0, 32'h0);
    wait_idle("t5b");
    gap_mode = 1'b0;
    if (seen_addr_q.size() != 0) check("t5_skip_addr", seen_addr_q[0], 32'h2000_0A00);
    check("t5_disp_bank", disp_bank, 1'b0);

    // T7: set beats clear, and line count saturates at V_ACTIVE
    gnt_delay = 20;
    pulse(1'b1, 1'b0, 32'h3000_0000);
    repeat (5) tick();
    init_read_line = 1'b1;
    underrun_clr   = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("t7_set_wins", underrun, 1'b1);
    repeat (499) tick();
    init_read_line = 1'b0;
    check("t7_still_busy", busy, 1'b1);
    wait_idle("t7a");
    gnt_delay = 0;
    seen_addr_q.delete();
    pulse(1'b0, 1'b0, 32'h0);
    wait_idle("t7b");
    if (seen_addr_q.size() != 0) check("t7_sat_addr", seen_addr_q[0], 32'h3009_6000);
    check("t7_underrun_sticky", underrun, 1'b1);

    // T6: reset in the middle of a burst, then stray beats and a blanked pulse
    pulse(1'b1, 1'b0, 32'h4000_0000);
    repeat (40) tick();
    reset = 1'b1;
    tick();
    tick();
    check("t6_rst_req", mem_req, 1'b0);
    check("t6_rst_we", lb_we, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_disp", disp_bank, 1'b1);
    check("t6_rst_underrun", underrun, 1'b0);
    reset = 1'b0;
    tick();
    stray_req = stray_req + 5;
    cnt = 0;
    repeat (10) begin
      @(negedge pixel_clk);
      if (lb_we) cnt++;
    end
    tick();
    check("t6_stray_no_we", cnt, 0);
    pulse(1'b0, 1'b1, 32'h0);
    count_req(20, cnt);
    check("t6_blank_no_req", cnt, 0);
    check("t6_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
